// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apu_pkg
//  Description : Shared types and default sizing for the APU multi-voice
//                PWM tone generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package apu_pkg;

   // Voice lifecycle: idle and waiting for a note, or playing one.
   typedef enum logic [0:0] {
      VOICE_IDLE = 1'b0,
      VOICE_PLAY = 1'b1
   } voice_state_e;

   localparam int c_channels_def = 4;
   localparam int c_period_w_def = 16;
   localparam int c_duty_w_def   = 8;
   localparam int c_dur_w_def    = 16;
   localparam int c_tick_div_def = 50000;
   localparam int c_decay_tk_def = 64;

   // Width of a voice index; a single voice still gets a 1-bit select.
   function automatic int ch_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apu_pwm_voices_if.sv
`default_nettype none
// ============================================================================
//  Module      : apu_pwm_voices_if
//  Description : Note request channel (valid/ready) into the voice bank.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apu_pwm_voices_if #(
   parameter int CHANNELS = 4,
   parameter int PERIOD_W = 16,
   parameter int DUTY_W   = 8,
   parameter int DUR_W    = 16
);
   localparam int c_ch_w = apu_pkg::ch_width(CHANNELS);

   logic                note_valid;
   logic                note_ready;
   logic [c_ch_w-1:0]   note_ch;
   logic [PERIOD_W-1:0] note_period;
   logic [DUTY_W-1:0]   note_duty;
   logic [DUR_W-1:0]    note_dur;

   modport master (
      output note_valid, note_ch, note_period, note_duty, note_dur,
      input  note_ready
   );

   modport slave (
      input  note_valid, note_ch, note_period, note_duty, note_dur,
      output note_ready
   );
endinterface
`default_nettype wire

// File: rtl/apu_pwm_voice.sv
`default_nettype none
// ============================================================================
//  Module      : apu_pwm_voice
//  Description : One PWM voice: accepts a note, generates the tone for the
//                requested number of ticks, then pulses done.
//                Optional duty decay is enabled with `define APU_DECAY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module apu_pwm_voice
   import apu_pkg::*;
#(
   parameter int PERIOD_W = c_period_w_def,
   parameter int DUTY_W   = c_duty_w_def,
   parameter int DUR_W    = c_dur_w_def
`ifdef APU_DECAY_EN
   ,
   parameter int DECAY_TK = c_decay_tk_def
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_tick,
   input  logic                i_accept,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic [DUTY_W-1:0]   i_duty,
   input  logic [DUR_W-1:0]    i_dur,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_pwm
);
   localparam int c_prod_w = PERIOD_W + DUTY_W;

   voice_state_e        r_state,  w_state_nxt;
   logic [PERIOD_W-1:0] r_period, w_period_nxt;
   logic [PERIOD_W-1:0] r_phase,  w_phase_nxt;
   logic [PERIOD_W-1:0] r_cmp,    w_cmp_nxt;
   logic [DUR_W-1:0]    r_dur,    w_dur_nxt;
   logic                r_pwm,    w_pwm_nxt;
   logic                w_done;
   logic                w_decay_step;
   logic [c_prod_w-1:0] w_prod;
   logic [PERIOD_W-1:0] w_cmp_new;

   // Compare threshold: full-width product scaled back down by the duty width.
   assign w_prod    = c_prod_w'(i_period) * c_prod_w'(i_duty);
   assign w_cmp_new = PERIOD_W'(w_prod >> DUTY_W);

`ifdef APU_DECAY_EN
   localparam int c_dk_w = $clog2(DECAY_TK + 1);
   logic [c_dk_w-1:0] r_decay;

   assign w_decay_step = (r_state == VOICE_PLAY) && i_tick &&
                         (r_decay == c_dk_w'(DECAY_TK - 1));

   // Count ticks since accept; every DECAY_TK ticks the threshold halves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                r_decay <= '0;
      else if (i_accept)                         r_decay <= '0;
      else if (w_decay_step)                     r_decay <= '0;
      else if ((r_state == VOICE_PLAY) && i_tick) r_decay <= r_decay + 1'b1;
   end
`else
   assign w_decay_step = 1'b0;
`endif

   // Next-state logic; pwm is registered from next-state phase/cmp so it
   // goes high in the first cycle after accept when the threshold is non-zero.
   always_comb begin
      w_state_nxt  = r_state;
      w_period_nxt = r_period;
      w_phase_nxt  = r_phase;
      w_cmp_nxt    = r_cmp;
      w_dur_nxt    = r_dur;
      w_done       = 1'b0;
      case (r_state)
         VOICE_IDLE: begin
            if (i_accept) begin
               w_period_nxt = i_period;
               w_phase_nxt  = '0;
               w_cmp_nxt    = w_cmp_new;
               w_dur_nxt    = i_dur;
               if (i_dur != '0) w_state_nxt = VOICE_PLAY;
            end
         end
         VOICE_PLAY: begin
            if ((r_period == '0) || (r_phase == r_period - 1'b1)) w_phase_nxt = '0;
            else                                                   w_phase_nxt = r_phase + 1'b1;
            if (w_decay_step) w_cmp_nxt = r_cmp >> 1;
            if (i_tick) begin
               if (r_dur == DUR_W'(1)) begin
                  w_state_nxt = VOICE_IDLE;
                  w_done      = 1'b1;
               end else begin
                  w_dur_nxt = r_dur - 1'b1;
               end
            end
         end
         default: w_state_nxt = VOICE_IDLE;
      endcase
      w_pwm_nxt = (w_state_nxt == VOICE_PLAY) && (w_phase_nxt < w_cmp_nxt);
   end

   // Voice state registers; reset aborts a note with no done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= VOICE_IDLE;
         r_period <= '0;
         r_phase  <= '0;
         r_cmp    <= '0;
         r_dur    <= '0;
         r_pwm    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_period <= w_period_nxt;
         r_phase  <= w_phase_nxt;
         r_cmp    <= w_cmp_nxt;
         r_dur    <= w_dur_nxt;
         r_pwm    <= w_pwm_nxt;
      end
   end

   assign o_busy = (r_state == VOICE_PLAY);
   assign o_done = w_done;
   assign o_pwm  = r_pwm;

endmodule
`default_nettype wire

// File: rtl/apu_pwm_voices.sv
`default_nettype none
// ============================================================================
//  Module      : apu_pwm_voices
//  Description : Bank of independent PWM voices fed by one note request
//                channel, with a shared duration prescaler and an OR-mixed
//                buzzer output. Duty decay is enabled with `define APU_DECAY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module apu_pwm_voices
   import apu_pkg::*;
#(
   parameter int CHANNELS = c_channels_def,
   parameter int PERIOD_W = c_period_w_def,
   parameter int DUTY_W   = c_duty_w_def,
   parameter int DUR_W    = c_dur_w_def,
   parameter int TICK_DIV = c_tick_div_def
`ifdef APU_DECAY_EN
   ,
   parameter int DECAY_TK = c_decay_tk_def
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   apu_pwm_voices_if.slave     bus,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                buzzer
);
   localparam int c_ch_w  = ch_width(CHANNELS);
   localparam int c_pad_w = 2 ** c_ch_w;
   localparam int c_pre_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [c_pre_w-1:0] r_presc;
   logic               w_tick;
   logic               w_ch_ok;
   logic               w_accept;
   logic [c_pad_w-1:0] w_busy_pad;
   logic               r_buzzer;

   assign w_tick = (r_presc == c_pre_w'(TICK_DIV - 1));

   // Free-running duration prescaler; wrap cycle is the shared tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + 1'b1;
   end

   // Indexes beyond the last voice only exist when CHANNELS is not a power of two.
   if (c_pad_w > CHANNELS) begin : g_ch_range
      assign w_ch_ok = (bus.note_ch < c_ch_w'(CHANNELS));
   end else begin : g_ch_full
      assign w_ch_ok = 1'b1;
   end

   assign w_busy_pad     = c_pad_w'(busy);
   assign bus.note_ready = w_ch_ok & ~w_busy_pad[bus.note_ch];
   assign w_accept       = bus.note_valid & bus.note_ready;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_voice
      logic w_acc_k;
      assign w_acc_k = w_accept & (bus.note_ch == c_ch_w'(k));

      apu_pwm_voice #(
         .PERIOD_W (PERIOD_W),
         .DUTY_W   (DUTY_W),
         .DUR_W    (DUR_W)
`ifdef APU_DECAY_EN
         ,
         .DECAY_TK (DECAY_TK)
`endif
      ) u_voice (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_tick   (w_tick),
         .i_accept (w_acc_k),
         .i_period (bus.note_period),
         .i_duty   (bus.note_duty),
         .i_dur    (bus.note_dur),
         .o_busy   (busy[k]),
         .o_done   (done[k]),
         .o_pwm    (pwm_out[k])
      );
   end

   // Pad driver: OR of all voices, one register stage behind pwm_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_buzzer <= 1'b0;
      else        r_buzzer <= |pwm_out;
   end

   assign buzzer = r_buzzer;

endmodule
`default_nettype wire

// File: tb/tb_apu_pwm_voices.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apu_pwm_voices
//  Description : Directed self-checking bench for apu_pwm_voices
//                (CHANNELS=4, TICK_DIV=10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apu_pwm_voices;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] busy, done, pwm_out;
   logic       buzzer;
   int         n_vec = 0;
   int         n_err = 0;
   int         tb_cyc;

   apu_pwm_voices_if #(.CHANNELS(4), .PERIOD_W(16), .DUTY_W(8), .DUR_W(16)) bus ();

   apu_pwm_voices #(
      .CHANNELS (4),
      .PERIOD_W (16),
      .DUTY_W   (8),
      .DUR_W    (16),
      .TICK_DIV (10)
`ifdef APU_DECAY_EN
      ,
      .DECAY_TK (2)
`endif
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .pwm_out (pwm_out),
      .buzzer  (buzzer)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; the prescaler is expected to equal tb_cyc mod 10.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cyc <= 0;
      else        tb_cyc <= tb_cyc + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input int ch, input int period, input int duty, input int dur, output bit ok);
      bus.note_valid  = 1'b1;
      bus.note_ch     = 2'(ch);
      bus.note_period = 16'(period);
      bus.note_duty   = 8'(duty);
      bus.note_dur    = 16'(dur);
      ok = 1'b0;
      #1;
      for (int w = 0; w < 200 && !ok; w++) begin
         if (bus.note_ready) ok = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (ok) begin
         @(posedge clk); #1;
      end
      bus.note_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int w = 0; w < 800 && !ok; w++) begin
         if (busy == 4'b0) ok = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
   endtask

   // Plays one note on an otherwise idle bank and tallies per-cycle
   // disagreement with the expected busy/pwm/done/buzzer waveforms.
   task automatic play_and_watch(input int ch, input int period, input int duty, input int dur,
                                 input int cmp0, input int dk,
                                 output int blen, output int errs, output int ndone);
      bit   ok;
      int   ka, md, k, t, c;
      logic be, pe, de, prev_or;
      blen = 0; errs = 0; ndone = 0; prev_or = 1'b0;
      send(ch, period, duty, dur, ok);
      if (!ok) begin
         errs = -1;
         return;
      end
      ka = tb_cyc;
      md = (ka / 10 + 1) * 10 + (dur - 1) * 10;
      for (int n = 0; n < md - ka + 3; n++) begin
         k  = ka + n;
         t  = k / 10 - ka / 10;
         c  = (dk > 0) ? (cmp0 >> (t / dk)) : cmp0;
         be = (t < dur);
         pe = be && (period != 0) && (((k - ka) % ((period != 0) ? period : 1)) < c);
         de = be && ((k + 1) % 10 == 0) && (t == dur - 1);
         if (busy[ch]) blen++;
         if (done[ch]) ndone++;
         if (busy[ch] !== be || pwm_out[ch] !== pe || done[ch] !== de || buzzer !== prev_or) errs++;
         prev_or = pe;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      bus.note_valid = 1'b0; bus.note_ch = 2'd0; bus.note_period = '0;
      bus.note_duty  = '0;   bus.note_dur = '0;
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (busy !== 4'b0)    begin n_err++; $display("FAIL reset_busy: got %b expected 0000", busy); end
      n_vec++; if (done !== 4'b0)    begin n_err++; $display("FAIL reset_done: got %b expected 0000", done); end
      n_vec++; if (pwm_out !== 4'b0) begin n_err++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
      n_vec++; if (buzzer !== 1'b0)  begin n_err++; $display("FAIL reset_buzzer: got %b expected 0", buzzer); end
      n_vec++; if (bus.note_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", bus.note_ready); end
      @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_note();
      int blen, errs, nd;
      play_and_watch(0, 100, 128, 3, 50, 0, blen, errs, nd);
      n_vec++; if (errs !== 0) begin n_err++; $display("FAIL note_wave: got %0d bad cycles expected 0", errs); end
      n_vec++; if (blen < 21 || blen > 30) begin n_err++; $display("FAIL note_busy_len: got %0d expected 21..30", blen); end
      n_vec++; if (nd !== 1) begin n_err++; $display("FAIL note_done_cnt: got %0d expected 1", nd); end
   endtask

   task automatic test_pwm_shape();
      int blen, errs, nd;
      play_and_watch(1, 100, 128, 25, 50, 0, blen, errs, nd);
      n_vec++; if (errs !== 0) begin n_err++; $display("FAIL shape_50_50: got %0d bad cycles expected 0", errs); end
      n_vec++; if (blen < 241 || blen > 250) begin n_err++; $display("FAIL shape_busy_len: got %0d expected 241..250", blen); end
   endtask

   task automatic test_backpressure();
      bit ok;
      send(0, 10, 128, 3, ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_first_accept: got %b expected 1", ok); end
      bus.note_valid = 1'b1; bus.note_ch = 2'd0; bus.note_period = 16'd7;
      bus.note_duty  = 8'd1; bus.note_dur = 16'd5;
      #1;
      n_vec++; if (bus.note_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_busy: got %b expected 0", bus.note_ready); end
      @(posedge clk); #1;
      n_vec++; if (bus.note_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_hold: got %b expected 0", bus.note_ready); end
      bus.note_ch = 2'd1;
      #1;
      n_vec++; if (bus.note_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_ch1: got %b expected 1", bus.note_ready); end
      @(posedge clk); #1;
      bus.note_valid = 1'b0;
      n_vec++; if (busy[1:0] !== 2'b11) begin n_err++; $display("FAIL bp_both_busy: got %b expected 11", busy[1:0]); end
      wait_idle(ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_idle_timeout: got %b expected 1", ok); end
   endtask

   task automatic test_back_to_back();
      bit ok, found;
      send(0, 4, 128, 1, ok);
      bus.note_valid = 1'b1; bus.note_ch = 2'd0; bus.note_period = 16'd4;
      bus.note_duty  = 8'd128; bus.note_dur = 16'd1;
      #1;
      found = 1'b0;
      for (int w = 0; w < 40 && !found; w++) begin
         if (done[0]) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL b2b_done_seen: got %b expected 1", found); end
      n_vec++; if (bus.note_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_at_done: got %b expected 0", bus.note_ready); end
      @(posedge clk); #1;
      n_vec++; if ({busy[0], bus.note_ready} !== 2'b01) begin n_err++; $display("FAIL b2b_after_done: got %b expected 01", {busy[0], bus.note_ready}); end
      @(posedge clk); #1;
      bus.note_valid = 1'b0;
      n_vec++; if ({busy[0], pwm_out[0]} !== 2'b11) begin n_err++; $display("FAIL b2b_restart: got %b expected 11", {busy[0], pwm_out[0]}); end
      wait_idle(ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_idle_timeout: got %b expected 1", ok); end
   endtask

   task automatic test_edges();
      int blen, errs, nd, bad;
      bit ok;
      play_and_watch(0, 50, 0, 2, 0, 0, blen, errs, nd);
      n_vec++; if (errs !== 0) begin n_err++; $display("FAIL duty0_wave: got %0d bad cycles expected 0", errs); end
      n_vec++; if (blen < 11 || blen > 20) begin n_err++; $display("FAIL duty0_busy_len: got %0d expected 11..20", blen); end
      play_and_watch(1, 256, 255, 60, 255, 0, blen, errs, nd);
      n_vec++; if (errs !== 0) begin n_err++; $display("FAIL duty255_wave: got %0d bad cycles expected 0", errs); end
      n_vec++; if (nd !== 1) begin n_err++; $display("FAIL duty255_done_cnt: got %0d expected 1", nd); end
      play_and_watch(2, 0, 128, 4, 0, 0, blen, errs, nd);
      n_vec++; if (errs !== 0) begin n_err++; $display("FAIL rest_wave: got %0d bad cycles expected 0", errs); end
      n_vec++; if (blen < 31 || blen > 40) begin n_err++; $display("FAIL rest_busy_len: got %0d expected 31..40", blen); end
      send(3, 10, 128, 0, ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL dur0_consumed: got %b expected 1", ok); end
      bad = 0;
      for (int n = 0; n < 15; n++) begin
         if (busy[3] !== 1'b0 || done[3] !== 1'b0 || pwm_out[3] !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL dur0_stays_idle: got %0d active cycles expected 0", bad); end
   endtask

   task automatic test_async_reset();
      int blen, errs, nd, bad;
      bit ok;
      send(2, 20, 128, 10, ok);
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_vec++; if ({busy[2], pwm_out[2], buzzer} !== 3'b111) begin n_err++; $display("FAIL rst_pre_state: got %b expected 111", {busy[2], pwm_out[2], buzzer}); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if ({busy, done, pwm_out, buzzer} !== 13'b0) begin n_err++; $display("FAIL rst_async_clear: got %b expected all 0", {busy, done, pwm_out, buzzer}); end
      @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
      bad = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (busy !== 4'b0 || done !== 4'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rst_voice_idle: got %0d active cycles expected 0", bad); end
      play_and_watch(2, 20, 128, 2, 10, 0, blen, errs, nd);
      n_vec++; if (errs !== 0) begin n_err++; $display("FAIL rst_replay_wave: got %0d bad cycles expected 0", errs); end
   endtask

`ifdef APU_DECAY_EN
   task automatic test_decay();
      int blen, errs, nd;
      play_and_watch(0, 64, 128, 8, 32, 2, blen, errs, nd);
      n_vec++; if (errs !== 0) begin n_err++; $display("FAIL decay_wave: got %0d bad cycles expected 0", errs); end
      n_vec++; if (nd !== 1) begin n_err++; $display("FAIL decay_done_cnt: got %0d expected 1", nd); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_note();
      test_pwm_shape();
      test_backpressure();
      test_back_to_back();
      test_edges();
      test_async_reset();
`ifdef APU_DECAY_EN
      test_decay();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
